// File: rtl/lstm_step_scheduler.sv
// Sample-paced timestep sequencer for the LSTM demodulator: one accepted I/Q sample
// drives one MAC phase, one activation/update phase, and advances the step index.
//   state | meaning
//   IDLE  | no symbol in progress
//   CLR   | clear recurrent h/c state
//   WAIT  | waiting for the next chip sample
//   MAC   | matrix multiply, MAC_CYC cycles
//   ACT   | gate activation and hidden update, ACT_CYC cycles
//   DONE  | final hidden state valid for the classifier
module lstm_step_scheduler #(
    parameter int T_STEPS = 32,
    parameter int STEP_W  = 5,
    parameter int MAC_CYC = 2,
    parameter int ACT_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              state_clr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              fun_cell_en,
    output logic              hidden_en,
    output logic [STEP_W-1:0] step_idx,
    output logic              sym_done,
    output logic              busy
);

    localparam int PH_MAX = (MAC_CYC > ACT_CYC) ? MAC_CYC : ACT_CYC;
    localparam int PH_W   = $clog2(PH_MAX);

    localparam logic [PH_W-1:0]   MAC_LAST  = PH_W'(MAC_CYC - 1);
    localparam logic [PH_W-1:0]   ACT_LAST  = PH_W'(ACT_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(T_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WAIT,
        S_MAC,
        S_ACT,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [PH_W-1:0]   ph, ph_n;
    logic [STEP_W-1:0] step_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ph       <= '0;
            step_idx <= '0;
        end else begin
            state    <= state_n;
            ph       <= ph_n;
            step_idx <= step_n;
        end
    end

    always_comb begin
        state_n = state;
        ph_n    = ph;
        step_n  = step_idx;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_n = S_CLR;
                end
            end
            S_CLR: begin
                state_n = S_WAIT;
                ph_n    = '0;
                step_n  = '0;
            end
            S_WAIT: begin
                if (in_valid) begin
                    state_n = S_MAC;
                    ph_n    = '0;
                end
            end
            S_MAC: begin
                if (ph == MAC_LAST) begin
                    state_n = S_ACT;
                    ph_n    = '0;
                end else begin
                    ph_n = ph + PH_W'(1);
                end
            end
            S_ACT: begin
                if (ph == ACT_LAST) begin
                    ph_n = '0;
                    // exact compare: the step index must never wrap inside a symbol
                    if (step_idx == STEP_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_WAIT;
                        step_n  = step_idx + STEP_W'(1);
                    end
                end else begin
                    ph_n = ph + PH_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                ph_n    = '0;
                step_n  = '0;
            end
            default: begin
                state_n = S_IDLE;
                ph_n    = '0;
                step_n  = '0;
            end
        endcase

        // abort outranks every other transition once a symbol is under way
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            ph_n    = '0;
            step_n  = '0;
        end
    end

    always_comb begin
        in_ready    = (state == S_WAIT);
        state_clr   = (state == S_CLR);
        mac_en      = (state == S_MAC);
        mac_clr     = (state == S_MAC) && (ph == '0);
        fun_cell_en = (state == S_ACT) && (ph == '0);
        hidden_en   = (state == S_ACT) && (ph == ACT_LAST);
        sym_done    = (state == S_DONE);
        busy        = (state != S_IDLE);
    end

endmodule
